// File: rtl/arb8_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : arb8_sched_if
// Brief    : Request/grant bundle between the requesting units and arb8_sched.
// Revision : 1.0 - initial release
// ============================================================================
// "release" is a reserved word in SystemVerilog, so the owner-release line
// is carried as rel.
interface arb8_sched_if;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       any_req;
    logic       timeout;

    modport master (
        output en, mode, req, rel,
        input  gnt, gnt_id, busy, any_req, timeout
    );

    modport slave (
        input  en, mode, req, rel,
        output gnt, gnt_id, busy, any_req, timeout
    );
endinterface
`default_nettype wire

// File: rtl/arb8_sched.sv
`default_nettype none
// ============================================================================
// Module   : arb8_sched
// Brief    : Eight-requester fixed-priority / round-robin arbiter with hold
//            limit, one-cycle gap between owners and registered grant outputs.
// Revision : 1.0 - initial release
// ============================================================================
module arb8_sched #(
    parameter int MAX_HOLD = 15
) (
    input  wire logic    clk,
    input  wire logic    rst,
    arb8_sched_if.slave  bus
);

    localparam int c_cnt_w = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_gnt, w_gnt_nxt;
    logic [2:0]           r_gnt_id, w_gnt_id_nxt;
    logic [2:0]           r_last, w_last_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_timeout, w_timeout_nxt;

    logic [2:0]           w_fp_id;
    logic [2:0]           w_rr_id;
    logic                 w_rr_found;
    logic [2:0]           w_win_id;

    // Fixed priority: the last set bit in an ascending scan is the highest index.
    always_comb begin
        w_fp_id = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (bus.req[k]) begin
                w_fp_id = 3'(k);
            end
        end
    end

    // Round-robin: scan last+1 .. last+8, the 3-bit sum wrapping modulo 8.
    always_comb begin
        w_rr_id    = 3'd0;
        w_rr_found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!w_rr_found && bus.req[r_last + 3'(k)]) begin
                w_rr_found = 1'b1;
                w_rr_id    = r_last + 3'(k);
            end
        end
    end

    assign w_win_id = bus.mode ? w_rr_id : w_fp_id;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.en && (|bus.req)) begin
                    w_state_nxt  = S_GRANT;
                    w_gnt_nxt    = 8'b1 << w_win_id;
                    w_gnt_id_nxt = w_win_id;
                    w_last_nxt   = w_win_id;
                    w_cnt_nxt    = '0;
                end
            end
            S_GRANT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                // Revoke and release outrank the hold limit, so only a pure
                // hold-limit exit raises timeout.
                if (!bus.en || bus.rel || !bus.req[r_gnt_id]) begin
                    w_state_nxt  = S_GAP;
                    w_gnt_nxt    = 8'h00;
                    w_gnt_id_nxt = 3'd0;
                end else if (r_cnt == c_hold_last) begin
                    w_state_nxt   = S_GAP;
                    w_gnt_nxt     = 8'h00;
                    w_gnt_id_nxt  = 3'd0;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_gnt_nxt    = 8'h00;
                w_gnt_id_nxt = 3'd0;
                w_cnt_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= 8'h00;
            r_gnt_id  <= 3'd0;
            r_last    <= 3'd7;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_id  = r_gnt_id;
    assign bus.busy    = (r_state == S_GRANT);
    assign bus.timeout = r_timeout;
    assign bus.any_req = |bus.req;

endmodule
`default_nettype wire

// File: tb/tb_arb8_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb8_sched
// Brief    : Directed self-checking bench for arb8_sched (MAX_HOLD = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb8_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    arb8_sched_if bus();

    arb8_sched #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Grant must never carry more than one set bit.
    always @(negedge clk) begin
        checks++;
        if ($countones(bus.gnt) > 1) begin
            failures++;
            $display("FAIL onehot: gnt=%b has %0d bits set, at most 1 allowed", bus.gnt, $countones(bus.gnt));
        end
    end

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.req = 8'h00;
        bus.rel = 1'b0;
        bus.en  = 1'b1;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.mode = 1'b0; bus.req = 8'h00; bus.rel = 1'b0;
        do_reset();
        checks++; if (bus.gnt !== 8'h00) begin failures++; $display("FAIL rst_gnt: got %h want 00", bus.gnt); end
        checks++; if (bus.gnt_id !== 3'd0) begin failures++; $display("FAIL rst_id: got %0d want 0", bus.gnt_id); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout: got %b want 0", bus.timeout); end
        checks++; if (bus.any_req !== 1'b0) begin failures++; $display("FAIL rst_any_req: got %b want 0", bus.any_req); end
    endtask

    task automatic test_fixed_priority();
        bus.mode = 1'b0; bus.en = 1'b1; bus.req = 8'b0010_0110;
        tick();
        checks++; if (bus.gnt !== 8'h20) begin failures++; $display("FAIL fp_gnt: got %h want 20", bus.gnt); end
        checks++; if (bus.gnt_id !== 3'd5) begin failures++; $display("FAIL fp_id: got %0d want 5", bus.gnt_id); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL fp_busy: got %b want 1", bus.busy); end
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        checks++; if (bus.gnt !== 8'h00) begin failures++; $display("FAIL fp_gap_gnt: got %h want 00", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL fp_gap_busy: got %b want 0", bus.busy); end
        checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL fp_gap_timeout: got %b want 0", bus.timeout); end
        tick();
        checks++; if (bus.gnt !== 8'h00) begin failures++; $display("FAIL fp_idle_gnt: got %h want 00", bus.gnt); end
        tick();
        checks++; if (bus.gnt !== 8'h20 || bus.gnt_id !== 3'd5) begin failures++; $display("FAIL fp_regrant: got %h/%0d want 20/5", bus.gnt, bus.gnt_id); end
        bus.rel = 1'b1;
        tick();
        drain();
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.mode = 1'b1; bus.en = 1'b1; bus.req = 8'hFF; bus.rel = 1'b0;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] exp_id;
            logic [7:0] exp_gnt;
            exp_id  = 3'(k % 8);
            exp_gnt = 8'h01 << exp_id;
            tick();
            checks++; if (bus.gnt !== exp_gnt || bus.gnt_id !== exp_id) begin failures++; $display("FAIL rr_grant[%0d]: got %h/%0d want %h/%0d", k, bus.gnt, bus.gnt_id, exp_gnt, exp_id); end
            bus.rel = 1'b1;
            tick();
            bus.rel = 1'b0;
            checks++; if (bus.gnt !== 8'h00) begin failures++; $display("FAIL rr_gap[%0d]: got %h want 00", k, bus.gnt); end
            tick();
            checks++; if (bus.gnt !== 8'h00) begin failures++; $display("FAIL rr_idle[%0d]: got %h want 00", k, bus.gnt); end
        end
        drain();
    endtask

    task automatic test_hold_limit();
        do_reset();
        bus.mode = 1'b0; bus.en = 1'b1; bus.req = 8'h08; bus.rel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.gnt !== 8'h08 || bus.timeout !== 1'b0) begin failures++; $display("FAIL hold_cycle[%0d]: got gnt=%h to=%b want 08/0", k, bus.gnt, bus.timeout); end
        end
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.timeout !== 1'b1) begin failures++; $display("FAIL hold_timeout: got gnt=%h to=%b want 00/1", bus.gnt, bus.timeout); end
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin failures++; $display("FAIL hold_idle: got gnt=%h to=%b want 00/0", bus.gnt, bus.timeout); end
        tick();
        checks++; if (bus.gnt !== 8'h08 || bus.gnt_id !== 3'd3) begin failures++; $display("FAIL hold_regrant: got %h/%0d want 08/3", bus.gnt, bus.gnt_id); end
        tick();
        tick();
        tick();
        checks++; if (bus.gnt !== 8'h08) begin failures++; $display("FAIL hold_4th: got %h want 08", bus.gnt); end
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        checks++; if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin failures++; $display("FAIL hold_release_wins: got gnt=%h to=%b want 00/0", bus.gnt, bus.timeout); end
        drain();
    endtask

    task automatic test_owner_drop();
        bus.mode = 1'b0; bus.en = 1'b1; bus.req = 8'hC0;
        tick();
        checks++; if (bus.gnt !== 8'h80 || bus.gnt_id !== 3'd7) begin failures++; $display("FAIL drop_first: got %h/%0d want 80/7", bus.gnt, bus.gnt_id); end
        bus.req = 8'h40;
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin failures++; $display("FAIL drop_gap: got gnt=%h to=%b want 00/0", bus.gnt, bus.timeout); end
        tick();
        tick();
        checks++; if (bus.gnt !== 8'h40 || bus.gnt_id !== 3'd6) begin failures++; $display("FAIL drop_next: got %h/%0d want 40/6", bus.gnt, bus.gnt_id); end
        drain();
    endtask

    task automatic test_enable();
        bus.mode = 1'b0; bus.en = 1'b0; bus.req = 8'h01;
        #1;
        checks++; if (bus.any_req !== 1'b1) begin failures++; $display("FAIL en_any_req: got %b want 1", bus.any_req); end
        tick();
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin failures++; $display("FAIL en_blocked: got gnt=%h busy=%b want 00/0", bus.gnt, bus.busy); end
        bus.en = 1'b1;
        tick();
        checks++; if (bus.gnt !== 8'h01 || bus.gnt_id !== 3'd0) begin failures++; $display("FAIL en_grant: got %h/%0d want 01/0", bus.gnt, bus.gnt_id); end
        bus.en = 1'b0;
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin failures++; $display("FAIL en_revoke: got gnt=%h to=%b want 00/0", bus.gnt, bus.timeout); end
        tick();
        tick();
        checks++; if (bus.gnt !== 8'h00) begin failures++; $display("FAIL en_held_off: got %h want 00", bus.gnt); end
        bus.en = 1'b1;
        tick();
        checks++; if (bus.gnt !== 8'h01) begin failures++; $display("FAIL en_regrant: got %h want 01", bus.gnt); end
        drain();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.mode = 1'b1; bus.en = 1'b1; bus.req = 8'h10;
        tick();
        checks++; if (bus.gnt_id !== 3'd4 || bus.busy !== 1'b1) begin failures++; $display("FAIL rmg_setup: got id=%0d busy=%b want 4/1", bus.gnt_id, bus.busy); end
        rst = 1'b1;
        bus.req = 8'hFF;
        tick();
        checks++; if (bus.gnt !== 8'h00 || bus.gnt_id !== 3'd0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin failures++; $display("FAIL rmg_cleared: got gnt=%h id=%0d busy=%b to=%b want all 0", bus.gnt, bus.gnt_id, bus.busy, bus.timeout); end
        rst = 1'b0;
        tick();
        checks++; if (bus.gnt !== 8'h01 || bus.gnt_id !== 3'd0) begin failures++; $display("FAIL rmg_pointer: got %h/%0d want 01/0", bus.gnt, bus.gnt_id); end
        drain();
    endtask

    initial begin
        bus.en = 1'b0; bus.mode = 1'b0; bus.req = 8'h00; bus.rel = 1'b0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_hold_limit();
        test_owner_drop();
        test_enable();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
